conv_window_3x3: RTL
====================

CONV_WINDOW_3X3 -- requirements
Module: conv_window_3x3

Interface
REQ-001 Parameter IMG_W, default 28, pixels per image row (legal range 3..1024).
REQ-002 Parameter IMG_H, default 28, rows per image (legal range 3..1024).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous frame restart; takes priority over in_valid.
REQ-006 in_valid  input  1  in_data carries a pixel this cycle.
REQ-007 in_data  input  22 (DATSIZE)  signed pixel, raster order (row-major, left to right).
REQ-008 out_valid  output  1  win0..win8 hold a complete 3x3 window this cycle.
REQ-009 win0..win8  output  22 each  signed window taps.
- win0..win2: top row (oldest); win6..win8: bottom row; left to right within each row.
- win8 is the newest pixel.
REQ-010 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-011 A pixel shall be accepted on every clock edge with in_valid=1 and clear=0; there is no backpressure.
REQ-012 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) shall advance only on acceptance.
- col wraps to 0 and row increments at IMG_W-1.
- Both wrap to 0 after (IMG_W-1, IMG_H-1).
REQ-013 Two row-delay line buffers, each IMG_W deep, shall supply the pixels at the same column one and two rows above the incoming pixel.
REQ-014 A 3x3 shift register shall shift left by one column on each acceptance, loading (row-2, row-1, row) pixels into the right column.
REQ-015 Windows use valid padding: out_valid=1 exactly one cycle after accepting a pixel with row>=2 and col>=2.
- Taps are registered; latency is 1 cycle.
- This yields (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-016 out_valid shall be 0 in all other cycles, including cycles with in_valid=0 (no output repeats).
REQ-017 win taps shall hold their last value while out_valid=0.
REQ-018 FSM states:
- FILL: row<2; out_valid is never asserted.
- RUN: row>=2.
- Transitions: FILL->RUN on accepting pixel (IMG_W-1, 1). RUN->FILL on accepting the final pixel of the frame, or on clear.
REQ-019 frame_done shall pulse in the cycle after the final pixel (IMG_W-1, IMG_H-1) is accepted, coincident with that window's out_valid.
REQ-020 On clear=1:
- col, row and FSM go to 0/FILL.
- out_valid and frame_done go to 0 on the next cycle.
- Line-buffer contents need not be cleared; stale data shall never appear in a valid window.
REQ-021 No arithmetic is performed; taps are bit-exact copies of accepted pixels.

Reset
REQ-022 While rst_n=0:
- out_valid=0, frame_done=0, win0..win8=0.
- col=0, row=0, FSM=FILL.
REQ-023 Assertion of rst_n mid-frame shall abort the frame; the first pixel after release is treated as (0,0).
REQ-024 Line-buffer storage may be left unreset (RAM inference allowed); reset correctness relies on REQ-020/REQ-023 gating.

Structure
REQ-025 DATSIZE (22), PARSIZE (16) and FPSHIFT (14) shall live in the shared nn package, together with the window tap count (9); this block uses only DATSIZE.
REQ-026 Sub-module line_buffer (parameter DEPTH, DATSIZE wide, shift-on-enable, read value = value written DEPTH enables earlier) shall be instantiated twice.
REQ-027 Target size is 120-400 lines of RTL; no combinational path from in_data to win taps.

Verification (IMG_W=4, IMG_H=4 unless stated)
REQ-028 Basic frame:
- Stimulus: pixels 0..15, in_valid continuous.
- First out_valid the cycle after pixel 10, with taps 0,1,2,4,5,6,8,9,10.
- Exactly 4 windows; the last has taps 5,6,7,9,10,11,13,14,15, with frame_done high in that same cycle.
REQ-029 Gapped input:
- Stimulus: same frame with in_valid toggling 1,0,1,0.
- Same 4 windows in the same order; out_valid never set in a gap cycle.
REQ-030 Back-to-back frames:
- Stimulus: pixels 0..15 then 100..115 with no gap.
- The second frame's first window is 100,101,102,104,105,106,108,109,110.
- No window mixes data from the two frames.
REQ-031 Mid-frame restart:
- Stimulus: clear after pixel 9, then pixels 0..15.
- Output identical to REQ-028.
- The same check is repeated with rst_n pulsed low asynchronously instead of clear.
REQ-032 Large frame with signed extremes:
- Stimulus: IMG_W=IMG_H=28 frame containing -2097152 and 2097151.
- 676 windows; extremes appear bit-exact in the expected tap positions.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared numeric formats and window constants for the nn datapath blocks
//   DATSIZE  activation/pixel width
//   PARSIZE  weight width
//   FPSHIFT  fixed-point fraction bits
//   NTAPS    taps in a 3x3 window
package nn_pkg;
    localparam int DATSIZE = 22;
    localparam int PARSIZE = 16;
    localparam int FPSHIFT = 14;
    localparam int NTAPS   = 9;
    typedef logic signed [DATSIZE-1:0] pix_t;
    typedef enum logic {FILL, RUN} win_state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: fixed-delay row buffer; dout is the value written DEPTH enables earlier
//   clk, rst_n  clock, async active-low reset (pointer only)
//   en          shift enable: write din and advance
//   din, dout   pixel in, pixel delayed by DEPTH enables
module line_buffer
    import nn_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  pix_t din,
    output pix_t dout
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    pix_t          mem [DEPTH];
    logic [AW-1:0] ptr;
    // circular buffer: the slot about to be overwritten holds the oldest entry
    assign dout = mem[ptr];
    always_ff @(posedge clk)
        if (en) mem[ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (en) ptr <= ptr == AW'(DEPTH - 1) ? '0 : ptr + AW'(1);
endmodule

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: raster pixel stream to registered 3x3 sliding windows (valid padding)
//   clk, rst_n      clock, async active-low reset
//   clear           sync frame restart, overrides in_valid
//   in_valid/data   raster-order signed pixel input, no backpressure
//   out_valid       win0..win8 hold a new window (one cycle after its newest pixel)
//   win0..win8      taps, top row first, left to right; win8 newest
//   frame_done      pulses with the window of the frame's last pixel
module conv_window_3x3
    import nn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic in_valid,
    input  pix_t in_data,
    output logic out_valid,
    output pix_t win0,
    output pix_t win1,
    output pix_t win2,
    output pix_t win3,
    output pix_t win4,
    output pix_t win5,
    output pix_t win6,
    output pix_t win7,
    output pix_t win8,
    output logic frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    win_state_t    state, state_nxt;
    pix_t          d1, d2;
    // two newest columns of the window, rows top..bottom; the third column is the incoming one
    pix_t          sr  [6];
    pix_t          nxt [NTAPS];
    pix_t          win [NTAPS];
    logic          acc, col_end, row_end, last, fire;
    assign acc     = in_valid && !clear;
    assign col_end = col == CW'(IMG_W - 1);
    assign row_end = row == RW'(IMG_H - 1);
    assign last    = col_end && row_end;
    // RUN means row>=2, so the line buffers hold this frame's rows and never stale data
    assign fire    = acc && state == RUN && col >= CW'(2);
    assign nxt     = '{sr[0], sr[1], d2, sr[2], sr[3], d1, sr[4], sr[5], in_data};
    line_buffer #(.DEPTH(IMG_W)) u_lb1 (.clk(clk), .rst_n(rst_n), .en(acc), .din(in_data), .dout(d1));
    line_buffer #(.DEPTH(IMG_W)) u_lb2 (.clk(clk), .rst_n(rst_n), .en(acc), .din(d1), .dout(d2));
    always_comb begin
        state_nxt = state;
        if (clear) state_nxt = FILL;
        else if (acc && state == FILL && col_end && row == RW'(1)) state_nxt = RUN;
        else if (acc && last) state_nxt = FILL;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            state      <= FILL;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            sr         <= '{default: '0};
            win        <= '{default: '0};
        end else begin
            state      <= state_nxt;
            out_valid  <= fire;
            frame_done <= acc && last;
            if (clear) begin
                col <= '0;
                row <= '0;
            end else if (acc) begin
                col <= col_end ? '0 : col + CW'(1);
                if (col_end) row <= row_end ? '0 : row + RW'(1);
                sr  <= '{nxt[1], nxt[2], nxt[4], nxt[5], nxt[7], nxt[8]};
            end
            if (fire) win <= nxt;
        end
    assign win0 = win[0];
    assign win1 = win[1];
    assign win2 = win[2];
    assign win3 = win[3];
    assign win4 = win[4];
    assign win5 = win[5];
    assign win6 = win[6];
    assign win7 = win[7];
    assign win8 = win[8];
endmodule
